// File: rtl/mii_rx_framer.sv
// Generic synchronous FIFO, first-word-fall-through, used as the framer output queue.
// Latency: a written entry is visible on rd_dat the cycle after wr_vld&&wr_rdy.
// Backpressure: wr_rdy drops when full unless a read happens in the same cycle.
module mii_rx_fifo #(
    parameter int W  = 10,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         empty;
    logic         wr_en;
    logic         rd_en;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_vld = !empty;
    assign rd_en  = rd_vld && rd_rdy;
    assign wr_rdy = !full || rd_en;
    assign wr_en  = wr_vld && wr_rdy;
    // Masked so the output bus reads zero whenever nothing is queued.
    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

// MII receive framer: strips preamble/SFD, packs nibbles into bytes, tags last/err, counts frames.
// Latency: a byte is held one byte time so last can be tagged, then visible on m_* the cycle after push.
// Backpressure: m_ready stalls the output FIFO; overflow truncates the frame with an error terminator.
module mii_rx_framer #(
    parameter int FIFO_AW = 4,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mii_rx_dv,
    input  logic [3:0]  mii_rx_d,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        m_err,
    input  logic        m_ready,
    output logic [15:0] frame_ok_cnt,
    output logic [15:0] frame_err_cnt
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
    typedef struct packed {
        logic       err;
        logic       last;
        logic [7:0] dat;
    } entry_t;

    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);
    localparam entry_t      TERM  = '{err: 1'b1, last: 1'b1, dat: 8'h00};

    state_t      state, state_nxt;
    logic [3:0]  lo_nib;
    logic        half;
    logic        dv_q;
    logic [7:0]  hold_dat;
    logic        hold_vld;
    logic [10:0] byte_cnt;
    logic [10:0] cnt_nxt;
    logic        term_pend;
    logic        term_set;
    logic        push_vld;
    logic        push_rdy;
    logic        push_fire;
    logic        zero_err;
    logic        byte_done;
    logic        too_long;
    logic        ok_inc;
    logic        err_inc;
    entry_t      push_dat;
    entry_t      pop_dat;

    assign byte_done = (state == DATA) && mii_rx_dv && half;
    assign cnt_nxt   = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    assign too_long  = byte_done && (cnt_nxt > MAX_L);

    always_comb begin
        state_nxt = state;
        push_vld  = 1'b0;
        push_dat  = '0;
        term_set  = 1'b0;
        zero_err  = 1'b0;
        case (state)
            // Only a fresh dv rise starts a frame, so a reset released mid-frame is ignored.
            IDLE: begin
                if (mii_rx_dv && !dv_q) state_nxt = (mii_rx_d == 4'h5) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!mii_rx_dv)                            state_nxt = IDLE;
                else if (mii_rx_d == 4'h5)                 state_nxt = PREAMBLE;
                else if (mii_rx_d == 4'hD && !term_pend)   state_nxt = DATA;
                else                                       state_nxt = DROP;
            end
            DATA: begin
                if (!mii_rx_dv) begin
                    state_nxt = IDLE;
                    if (hold_vld) begin
                        push_vld = 1'b1;
                        push_dat = {(byte_cnt < MIN_L) || half, 1'b1, hold_dat};
                        term_set = !push_rdy;
                    end else begin
                        zero_err = 1'b1;
                    end
                end else if (byte_done) begin
                    push_vld = hold_vld;
                    push_dat = {1'b0, 1'b0, hold_dat};
                    if (too_long || (hold_vld && !push_rdy)) begin
                        term_set  = 1'b1;
                        state_nxt = DROP;
                    end
                end
            end
            DROP: begin
                if (!mii_rx_dv) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (term_pend) begin
            push_vld = 1'b1;
            push_dat = TERM;
        end
    end

    assign push_fire = push_vld && push_rdy;
    assign ok_inc    = push_fire && push_dat.last && !push_dat.err;
    assign err_inc   = (push_fire && push_dat.last && push_dat.err) || zero_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dv_q          <= 1'b1;
            half          <= 1'b0;
            lo_nib        <= 4'h0;
            hold_vld      <= 1'b0;
            hold_dat      <= 8'h00;
            byte_cnt      <= 11'd0;
            term_pend     <= 1'b0;
            frame_ok_cnt  <= 16'd0;
            frame_err_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            dv_q  <= mii_rx_dv;
            half  <= (state == DATA) && mii_rx_dv && !half;
            if ((state == DATA) && mii_rx_dv && !half) lo_nib <= mii_rx_d;
            if (state_nxt != DATA) begin
                hold_vld <= 1'b0;
                byte_cnt <= 11'd0;
            end else if (byte_done) begin
                hold_vld <= 1'b1;
                hold_dat <= {mii_rx_d, lo_nib};
                byte_cnt <= cnt_nxt;
            end
            if (term_set)                   term_pend <= 1'b1;
            else if (term_pend && push_rdy) term_pend <= 1'b0;
            if (ok_inc && (frame_ok_cnt != 16'hFFFF))   frame_ok_cnt  <= frame_ok_cnt + 16'd1;
            if (err_inc && (frame_err_cnt != 16'hFFFF)) frame_err_cnt <= frame_err_cnt + 16'd1;
        end
    end

    mii_rx_fifo #(
        .W  ($bits(entry_t)),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push_vld),
        .wr_rdy (push_rdy),
        .wr_dat (push_dat),
        .rd_vld (m_valid),
        .rd_rdy (m_ready),
        .rd_dat (pop_dat)
    );

    assign m_err  = pop_dat.err;
    assign m_last = pop_dat.last;
    assign m_data = pop_dat.dat;
endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench for mii_rx_framer: table of whole-frame scenarios plus overflow and mid-frame reset sequences.
module tb_mii_rx_framer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mii_rx_dv = 1'b0;
    logic [3:0]  mii_rx_d = 4'h0;
    logic        m_ready = 1'b1;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_err;
    logic [15:0] frame_ok_cnt;
    logic [15:0] frame_err_cnt;

    int          checks = 0;
    int          errors = 0;
    logic        rdy_q = 1'b1;
    logic [9:0]  rxq[$];
    logic [9:0]  expq[$];

    typedef struct {
        string name;
        bit    do_rst;
        int    nbytes;
        bit    odd;
        bit    exp_err;
        bit    exp_term;
        int    exp_ok;
        int    exp_ec;
    } vec_t;

    vec_t vecs[9];

    mii_rx_framer #(.FIFO_AW(4), .MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk           (clk),
        .rst           (rst),
        .mii_rx_dv     (mii_rx_dv),
        .mii_rx_d      (mii_rx_d),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_last        (m_last),
        .m_err         (m_err),
        .m_ready       (m_ready),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; an entry offered with ready is popped at the next rising edge.
    task automatic nib(input logic dv, input logic [3:0] d);
        @(negedge clk);
        mii_rx_dv = dv;
        mii_rx_d  = d;
        m_ready   = rdy_q;
        if (m_valid && m_ready && !rst) rxq.push_back({m_err, m_last, m_data});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) nib(1'b0, 4'h0);
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 15; i++) nib(1'b1, 4'h5);
        nib(1'b1, 4'hD);
    endtask

    task automatic send_frame(input int n, input bit odd);
        logic [7:0] b;
        send_preamble();
        for (int i = 0; i < n; i++) begin
            b = 8'(i);
            nib(1'b1, b[3:0]);
            nib(1'b1, b[7:4]);
        end
        if (odd) nib(1'b1, 4'hA);
        nib(1'b0, 4'h0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " outputs"}, int'({m_valid, m_last, m_err, m_data}), 0);
        check({name, " counters"}, int'({frame_ok_cnt, frame_err_cnt}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mii_rx_dv = 1'b0;
        #1;
        check_reset_outputs("in reset");
        @(negedge clk);
        rst = 1'b0;
        rxq.delete();
        idle(3);
    endtask

    function automatic void build_exp(input int n, input bit err_b, input bit term);
        int         nd;
        logic [7:0] b;
        logic       lst;
        expq.delete();
        nd = term ? 1518 : n;
        for (int i = 0; i < nd; i++) begin
            b   = 8'(i);
            lst = !term && (i == nd - 1);
            expq.push_back({lst & err_b, lst, b});
        end
        if (term) expq.push_back(10'h300);
    endfunction

    task automatic compare_rx(input string name);
        int bad   = 0;
        int first = -1;
        int n;
        check({name, " entry count"}, rxq.size(), expq.size());
        n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            if (rxq[i] !== expq[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        check($sformatf("%s wrong entries (first at %0d)", name, first), bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"good64",          1'b1, 64,   1'b0, 1'b0, 1'b0, 1, 0};
        vecs[1] = '{"short10",         1'b1, 10,   1'b0, 1'b1, 1'b0, 0, 1};
        vecs[2] = '{"align64",         1'b1, 64,   1'b1, 1'b1, 1'b0, 0, 1};
        vecs[3] = '{"short63",         1'b1, 63,   1'b0, 1'b1, 1'b0, 0, 1};
        vecs[4] = '{"max1518",         1'b1, 1518, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[5] = '{"long1600",        1'b1, 1600, 1'b0, 1'b0, 1'b1, 0, 1};
        vecs[6] = '{"good_after_long", 1'b0, 64,   1'b0, 1'b0, 1'b0, 1, 1};
        vecs[7] = '{"zero_len",        1'b1, 0,    1'b0, 1'b0, 1'b0, 0, 1};
        vecs[8] = '{"long1519",        1'b1, 1519, 1'b0, 1'b0, 1'b1, 0, 1};

        @(negedge clk);
        check_reset_outputs("power-on reset");
        rst = 1'b0;
        idle(3);
        check_reset_outputs("after reset release");

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].do_rst) do_reset();
            rdy_q = 1'b1;
            rxq.delete();
            send_frame(vecs[v].nbytes, vecs[v].odd);
            idle(40);
            build_exp(vecs[v].nbytes, vecs[v].exp_err, vecs[v].exp_term);
            compare_rx(vecs[v].name);
            check({vecs[v].name, " frame_ok_cnt"}, frame_ok_cnt, vecs[v].exp_ok);
            check({vecs[v].name, " frame_err_cnt"}, frame_err_cnt, vecs[v].exp_ec);
            check({vecs[v].name, " drained"}, m_valid, 0);
        end

        // Overflow: consumer stalled while a 100-byte frame arrives.
        do_reset();
        rdy_q = 1'b0;
        rxq.delete();
        send_frame(100, 1'b0);
        idle(5);
        check("overflow fifo held", m_valid, 1);
        check("overflow err_cnt before drain", frame_err_cnt, 0);
        rdy_q = 1'b1;
        idle(40);
        build_exp(16, 1'b0, 1'b0);
        expq[15] = 10'h00F;
        expq.push_back(10'h300);
        compare_rx("overflow");
        check("overflow frame_ok_cnt", frame_ok_cnt, 0);
        check("overflow frame_err_cnt", frame_err_cnt, 1);

        // Reset in the middle of a frame; the tail after release looks like a new preamble.
        do_reset();
        rdy_q = 1'b1;
        send_preamble();
        for (int i = 0; i < 20; i++) begin
            nib(1'b1, 4'h3);
            nib(1'b1, 4'h1);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid-frame reset");
        nib(1'b1, 4'h3);
        rst = 1'b0;
        rxq.delete();
        send_preamble();
        for (int i = 0; i < 10; i++) begin
            nib(1'b1, 4'h5);
            nib(1'b1, 4'h5);
        end
        nib(1'b0, 4'h0);
        idle(40);
        check("post-reset partial frame entries", rxq.size(), 0);
        check("post-reset frame_ok_cnt", frame_ok_cnt, 0);
        check("post-reset frame_err_cnt", frame_err_cnt, 0);
        rxq.delete();
        send_frame(64, 1'b0);
        idle(40);
        build_exp(64, 1'b0, 1'b0);
        compare_rx("after mid-frame reset");
        check("after mid-frame reset frame_ok_cnt", frame_ok_cnt, 1);
        check("after mid-frame reset frame_err_cnt", frame_err_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
